// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - sync, debounce, press-edge, arbitration and game-over gating for three game buttons; optional macro AUTO_REPEAT_EN
module btn_conditioner #(
  parameter int DEB_CYCLES   = 200,
  parameter int REPEAT_DELAY = 2500,
  parameter int REPEAT_RATE  = 800
) (
  input  logic clk_10000Hz,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  input  logic rotate_raw,
  input  logic stop,
  output logic left_btn,
  output logic right_btn,
  output logic rotate_btn
);

  // Button lanes: 0 = left, 1 = right, 2 = rotate.
  localparam logic [13:0] DEB_LAST = 14'(DEB_CYCLES - 1);

  // Both repeat intervals must fit the 14-bit repeat counter.
  if (REPEAT_DELAY > 16384 || REPEAT_RATE > 16384) begin : g_repeat_range_too_wide
  end

  logic [2:0]  raw;
  logic [2:0]  sync_a;
  logic [2:0]  sync_b;
  logic [2:0]  stable;
  logic [2:0]  stable_d;
  logic [2:0]  rise;
  logic [13:0] deb_cnt [3];

  assign raw  = {rotate_raw, right_raw, left_raw};
  assign rise = stable & ~stable_d;

  // Two-flop synchroniser per button; only sync_b is used downstream.
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      stable   <= '0;
      stable_d <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 14'd1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} h_state_t;
  localparam h_state_t    HOLD_ENTRY = DELAY;
  localparam logic [13:0] DELAY_LAST = 14'(REPEAT_DELAY - 1);
  localparam logic [13:0] RATE_LAST  = 14'(REPEAT_RATE - 1);
  logic [13:0] cnt;
  logic [13:0] cnt_next;
`else
  typedef enum logic [0:0] {IDLE, HELD} h_state_t;
  localparam h_state_t HOLD_ENTRY = HELD;
`endif

  h_state_t state;
  h_state_t state_next;
  logic     dir;          // 0 = left, 1 = right
  logic     dir_next;
  logic     dir_level;
  logic     other_level;
  logic     left_next;
  logic     right_next;
  logic     rotate_next;
  logic     rotate_pend;
  logic     pend_next;
  logic     rot_req;

  assign dir_level   = dir ? stable[1] : stable[0];
  assign other_level = dir ? stable[0] : stable[1];

  // Horizontal FSM next state plus rotate arbitration behind horizontal pulses.
  always_comb begin
    state_next  = state;
    dir_next    = dir;
    left_next   = 1'b0;
    right_next  = 1'b0;
    rotate_next = 1'b0;
    pend_next   = rotate_pend;
    rot_req     = rise[2] | rotate_pend;
`ifdef AUTO_REPEAT_EN
    cnt_next    = cnt;
`endif
    if (stop) begin
      state_next = IDLE;
      pend_next  = 1'b0;
`ifdef AUTO_REPEAT_EN
      cnt_next   = '0;
`endif
    end else begin
      if (rise[0]) begin
        left_next  = 1'b1;
        dir_next   = 1'b0;
        state_next = HOLD_ENTRY;
`ifdef AUTO_REPEAT_EN
        cnt_next   = '0;
`endif
      end else if (rise[1]) begin
        right_next = 1'b1;
        dir_next   = 1'b1;
        state_next = HOLD_ENTRY;
`ifdef AUTO_REPEAT_EN
        cnt_next   = '0;
`endif
      end else if (state != IDLE && !dir_level) begin
        // Released the active direction: hand over to the other one if it is held.
        if (other_level) begin
          dir_next   = ~dir;
          state_next = HOLD_ENTRY;
`ifdef AUTO_REPEAT_EN
          cnt_next   = '0;
`endif
        end else begin
          state_next = IDLE;
        end
      end
`ifdef AUTO_REPEAT_EN
      else if (state == DELAY || state == REPEAT) begin
        if ((state == DELAY && cnt == DELAY_LAST) || (state == REPEAT && cnt == RATE_LAST)) begin
          left_next  = ~dir;
          right_next = dir;
          state_next = REPEAT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 14'd1;
        end
      end
`endif
      // A horizontal pulse always wins the cycle; rotate waits one slot.
      rotate_next = rot_req & ~(left_next | right_next);
      pend_next   = rot_req & (left_next | right_next);
    end
  end

  // State, direction, pending rotate and registered command outputs.
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dir         <= 1'b0;
      rotate_pend <= 1'b0;
      left_btn    <= 1'b0;
      right_btn   <= 1'b0;
      rotate_btn  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      cnt         <= '0;
`endif
    end else begin
      state       <= state_next;
      dir         <= dir_next;
      rotate_pend <= pend_next;
      left_btn    <= left_next;
      right_btn   <= right_next;
      rotate_btn  <= rotate_next;
`ifdef AUTO_REPEAT_EN
      cnt         <= cnt_next;
`endif
    end
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Sits directly upstream of the falling-block move/rotate controller.
- Turns three raw, bouncing, asynchronous pushbuttons into clean single-cycle command pulses: left_btn, right_btn, rotate_btn.
- Each pulse means exactly one move or rotate step.
- Provides synchronisation, debounce, press-edge detection, one-pulse-per-cycle arbitration, game-over gating and optional horizontal auto-repeat.

Parameters:
- DEB_CYCLES, 200, consecutive stable cycles needed to accept a level change (20 ms at 10 kHz).
- REPEAT_DELAY, 2500, cycles from the initial horizontal pulse to the first repeat.
- REPEAT_RATE, 800, cycles between subsequent repeats.

Ports:
- clk_10000Hz  in  1  system clock, 10 kHz
- reset  in  1  asynchronous, active-low
- left_raw  in  1  raw left button, active-high, asynchronous
- right_raw  in  1  raw right button, active-high, asynchronous
- rotate_raw  in  1  raw rotate button, active-high, asynchronous
- stop  in  1  game-over flag; high suppresses all commands
- left_btn  out  1  one-cycle move-left pulse
- right_btn  out  1  one-cycle move-right pulse
- rotate_btn  out  1  one-cycle rotate pulse

Behaviour:
- Reset (async, reset low):
  - All outputs 0.
  - Synchroniser FFs, stable levels, debounce counters, repeat counter and rotate_pend all 0.
  - Horizontal FSM in IDLE.
- Sync: 2-FF synchroniser per button. All further logic uses only the synchronised level.
- Debounce, per button:
  - 14-bit counter cleared whenever sync == stable.
  - Counter increments while sync != stable.
  - When it reaches DEB_CYCLES-1, stable <= sync and counter clears.
  - Latency: raw held high from edge 0 gives a stable rise at edge DEB_CYCLES+2. Any shorter glitch is ignored.
- Edge detect: rise = stable & ~stable_d. A fall generates nothing.
- Outputs are registered. A command pulse is visible one cycle after its rise, i.e. DEB_CYCLES+3 = 203 cycles after the raw press.
- Horizontal FSM (states IDLE, DELAY, REPEAT; dir register L/R):
  - Any state, left rise: pulse left, dir=L, DELAY, cnt=0.
  - Else, right rise: pulse right, dir=R, DELAY, cnt=0.
  - Simultaneous left and right rises: left wins; right is ignored.
  - DELAY/REPEAT, stable of dir low:
    - If the other direction's stable is high: switch dir, go to DELAY, cnt=0, no pulse.
    - Otherwise go to IDLE.
  - DELAY, cnt==REPEAT_DELAY-1: pulse dir, go to REPEAT, cnt=0.
  - REPEAT, cnt==REPEAT_RATE-1: pulse dir, cnt=0.
  - cnt is 14-bit and never wraps, since it clears at its terminal value.
- Rotate: one pulse per rise, never repeats.
- Arbitration:
  - At most one output high in any cycle.
  - If a rotate rise coincides with a horizontal pulse, set rotate_pend.
  - rotate_btn is emitted on the first later cycle with no horizontal pulse, then rotate_pend clears.
  - At most one pending rotate is held; a second rise while pending is merged.
- stop high:
  - Outputs forced 0, FSM to IDLE, cnt=0, rotate_pend=0.
  - Synchronisers and debouncers keep running.
  - Rises occurring while stop is high are discarded.
  - Buttons still held when stop falls generate nothing until released and re-pressed.
- Reset mid-operation: immediate return to the reset state. A button held through reset deassertion is treated as a new press and pulses 203 cycles later.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: full DELAY/REPEAT auto-repeat as described above.
- Undefined:
  - FSM reduces to IDLE/HELD; one pulse per press only.
  - Repeat counter and REPEAT_DELAY/REPEAT_RATE logic are not instantiated; the parameters are accepted but unused.
  - Direction switch on release is still tracked, but produces no pulse.

Test Plan:
- Reset, then left_raw high for cycles 0–999 with macro undefined -> exactly one left_btn pulse at cycle 203; all other outputs 0 throughout.
- left_raw toggles every 50 cycles for 1000 cycles, then stays high -> no pulse during bouncing; one left_btn pulse 203 cycles after the final rise.
- AUTO_REPEAT_EN, right_raw high cycles 0–4999 -> right_btn pulses at cycles 203, 2703, 3503, 4303 and 5103 (5 total); none after the debounced release.
- left_raw and rotate_raw rise on the same edge -> left_btn at cycle 203, rotate_btn at cycle 204, never both high together.
- stop=1, press rotate_raw, drop stop at cycle 500 with the button still held -> no rotate_btn; after release and re-press, rotate_btn 203 cycles after the re-press.
- AUTO_REPEAT_EN, right held into REPEAT, reset pulsed low at cycle 3000 -> outputs 0 immediately; after release of reset with right still held, right_btn 203 cycles after reset goes high.
